spsa_measure_sched: RTL and testbench
=====================================

Name: spsa_measure_sched

Overview:
Sequences one A-SPSA gradient measurement around the NMSE error-metric datapath.
- Applies +Δ perturbation, waits for PA/feedback settling, then averages N error-metric results into J+.
- Repeats with −Δ to get J−, then emits ΔJ = J+ − J− to the coefficient-update logic.
- Sits between the SPSA optimiser (start/result) and the error-metric block (flush/metric_valid), and drives the perturbation-sign control of the DPD coefficient bank.

Parameters:
DATA_WIDTH, 16, width of metric_in / J± (Q8.8)
SETTLE_CYCLES, 256, clock cycles to wait after each perturbation is applied (≥1)
METRIC_SAMPLES, 4, metric_valid pulses averaged per phase (power of 2, ≥1)
AVG_SHIFT, 2, log2(METRIC_SAMPLES)
TIMEOUT_CYCLES, 4096, maximum cycles allowed in one measure phase
CNT_WIDTH, 16, width of the settle and timeout counters

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a measurement; honoured only in IDLE
abort  in  1  cancel any measurement in progress
metric_in  in  DATA_WIDTH  signed Q8.8 error metric
metric_valid  in  1  metric_in qualifier
metric_flush  out  1  one-cycle pulse that restarts the metric averaging window
perturb_en  out  1  perturbation applied to the coefficient bank
perturb_sign  out  1  1 = +Δ, 0 = −Δ
j_plus  out  DATA_WIDTH  averaged metric under +Δ
j_minus  out  DATA_WIDTH  averaged metric under −Δ
delta_j  out  DATA_WIDTH+1  signed j_plus − j_minus
result_valid  out  1  one-cycle pulse; j_plus, j_minus and delta_j are valid
busy  out  1  high in every state except IDLE
timeout_err  out  1  sticky; set on measure timeout, cleared by the next accepted start

Behaviour:
- Reset: every output is 0. State goes to IDLE and all counters and accumulators clear.
- States and transitions:
  - IDLE → APPLY_P on start.
  - APPLY_P (1 cycle) → SETTLE_P.
  - SETTLE_P (SETTLE_CYCLES cycles) → MEAS_P.
  - MEAS_P → APPLY_M after METRIC_SAMPLES valids.
  - APPLY_M (1 cycle) → SETTLE_M → MEAS_M → DONE.
  - DONE (1 cycle) → IDLE.
- APPLY_P: perturb_en=1, perturb_sign=1, metric_flush=1. APPLY_M: perturb_sign=0, metric_flush=1, perturb_en stays 1.
- SETTLE_x: metric_valid is ignored. The counter loads SETTLE_CYCLES−1 on entry and the state exits the cycle after it reaches 0.
- MEAS_x: each metric_valid adds sign-extended metric_in to an accumulator of width DATA_WIDTH+AVG_SHIFT. On the METRIC_SAMPLES-th valid, J± is registered as acc>>>AVG_SHIFT (arithmetic shift, truncation). The accumulator clears on entry to every MEAS state.
- DONE: delta_j = j_plus − j_minus, computed at full DATA_WIDTH+1 width, no saturation. result_valid=1 and perturb_en=0 in this cycle.
- Outputs are registered. j_plus and j_minus hold their values until overwritten by the next measurement.
- Latency, start to result_valid with no stalls on metric_valid: 2·(1+SETTLE_CYCLES+M)+2 cycles, where M is the number of cycles spent in MEAS.
- Timeout: a MEAS state lasting TIMEOUT_CYCLES cycles sets timeout_err, forces perturb_en=0, and goes to IDLE with no result_valid.
- abort:
  - Any state → IDLE on the next edge; perturb_en=0; no result_valid.
  - abort together with start in IDLE: abort wins and start is dropped.
- start while busy is ignored, with no queuing.
- metric_valid in IDLE, APPLY or SETTLE states is discarded.
- metric_valid in the same cycle as the final sample is counted normally. A valid arriving in the APPLY_M cycle is discarded.

Optional Feature:
SPSA_DISCARD_FIRST_EN
- Defined: in each MEAS state the first metric_valid is dropped, as a stale-window guard, so METRIC_SAMPLES+1 valids are needed per phase. The timeout rule is unchanged.
- Undefined: every metric_valid in MEAS is accumulated.

Decomposition:
- Shared package/include dpd_spsa_pkg holds:
  - state encodings: IDLE=0, APPLY_P, SETTLE_P, MEAS_P, APPLY_M, SETTLE_M, MEAS_M, DONE;
  - Q8.8 width constants;
  - sign encodings POS=1 and NEG=0.
- One sub-module is natural: spsa_meas_accum.
  - Inputs: clear, valid, data.
  - Outputs: count-done flag and the shifted average.
  - Instantiated once and reused for both phases.

Test Plan:
1. Params SETTLE=4, SAMPLES=4. start; +phase metrics 0x0100 ×4, −phase metrics 0x0080 ×4 → j_plus=0x0100, j_minus=0x0080, delta_j=+0x0080, one result_valid pulse, perturb_sign 1→0 at APPLY_M.
2. Negative average: +phase {−2,−1,−1,−1} → j_plus=−2 (0xFFFE, arithmetic-shift truncation). −phase 0x7FFF ×4 → delta_j=−0x8001, correct at 17 bits.
3. metric_valid pulses during SETTLE_P and APPLY_M → ignored; j± equal the MEAS-only average; metric_flush pulses exactly twice per run.
4. abort in MEAS_M, same cycle as a valid → next cycle busy=0, perturb_en=0, no result_valid; a following start runs cleanly.
5. TIMEOUT=16, no metric_valid in MEAS_P → timeout_err=1 at cycle 16 of MEAS_P, IDLE, no result_valid. Next start clears timeout_err.
6. start held high for the whole run plus abort+start together in IDLE → exactly one measurement runs; the abort+start cycle stays in IDLE.
   - With SPSA_DISCARD_FIRST_EN: 5 valids needed per phase, and the first value (0x7FFF) is excluded from the average.

Source files
------------

// File: rtl/dpd_spsa_pkg.sv
// Shared types and constants for the A-SPSA measurement scheduler: state encoding,
// Q8.8 width constants and perturbation-sign encoding.
package dpd_spsa_pkg;

  localparam int Q_INT_BITS  = 8;
  localparam int Q_FRAC_BITS = 8;
  localparam int Q_WIDTH     = Q_INT_BITS + Q_FRAC_BITS;

  localparam logic POS = 1'b1;
  localparam logic NEG = 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY_P  = 3'd1,
    SETTLE_P = 3'd2,
    MEAS_P   = 3'd3,
    APPLY_M  = 3'd4,
    SETTLE_M = 3'd5,
    MEAS_M   = 3'd6,
    DONE     = 3'd7
  } spsa_state_e;

  function automatic logic isMeas(input spsa_state_e s);
    return (s == MEAS_P) || (s == MEAS_M);
  endfunction

  function automatic logic isSettle(input spsa_state_e s);
    return (s == SETTLE_P) || (s == SETTLE_M);
  endfunction

  function automatic logic isPlusPhase(input spsa_state_e s);
    return (s == APPLY_P) || (s == SETTLE_P) || (s == MEAS_P);
  endfunction

endpackage

// File: rtl/spsa_meas_accum.sv
// Accumulates METRIC_SAMPLES error-metric values and presents the truncated average.
// Build option SPSA_DISCARD_FIRST_EN drops the first valid after each clear.
module spsa_meas_accum import dpd_spsa_pkg::*; #(
  parameter int DATA_WIDTH     = Q_WIDTH,
  parameter int METRIC_SAMPLES = 4,
  parameter int AVG_SHIFT      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] avg_o
);

  localparam int ACC_WIDTH = DATA_WIDTH + AVG_SHIFT;
  localparam int SCNT_WIDTH = (METRIC_SAMPLES > 1) ? $clog2(METRIC_SAMPLES) : 1;

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] dataExt;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [SCNT_WIDTH-1:0]       sampleCnt_q;
  logic                        take;

`ifdef SPSA_DISCARD_FIRST_EN
  logic firstDropped_q;
  assign take = valid_i && firstDropped_q;
`else
  assign take = valid_i;
`endif

  assign dataExt = ACC_WIDTH'(signed'(data_i));
  assign sum     = acc_q + dataExt;
  // The final sample is folded in combinationally so the average is ready on the same edge.
  assign done_o  = take && (sampleCnt_q == SCNT_WIDTH'(METRIC_SAMPLES - 1));
  assign avg_o   = DATA_WIDTH'(sum >>> AVG_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sampleCnt_q <= '0;
    end else if (clear_i) begin
      acc_q       <= '0;
      sampleCnt_q <= '0;
    end else if (take) begin
      acc_q       <= sum;
      sampleCnt_q <= sampleCnt_q + 1'b1;
    end
  end

`ifdef SPSA_DISCARD_FIRST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      firstDropped_q <= 1'b0;
    end else if (clear_i) begin
      firstDropped_q <= 1'b0;
    end else if (valid_i) begin
      firstDropped_q <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/spsa_measure_sched.sv
// Sequences one A-SPSA gradient measurement: +delta settle/average, -delta settle/average,
// then reports dJ = J+ - J-. Optional build macro: SPSA_DISCARD_FIRST_EN (see spsa_meas_accum).
module spsa_measure_sched import dpd_spsa_pkg::*; #(
  parameter int DATA_WIDTH     = Q_WIDTH,
  parameter int SETTLE_CYCLES  = 256,
  parameter int METRIC_SAMPLES = 4,
  parameter int AVG_SHIFT      = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_WIDTH-1:0] metric_in_i,
  input  logic                  metric_valid_i,
  output logic                  metric_flush_o,
  output logic                  perturb_en_o,
  output logic                  perturb_sign_o,
  output logic [DATA_WIDTH-1:0] j_plus_o,
  output logic [DATA_WIDTH-1:0] j_minus_o,
  output logic [DATA_WIDTH:0]   delta_j_o,
  output logic                  result_valid_o,
  output logic                  busy_o,
  output logic                  timeout_err_o
);

  spsa_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic inMeas, settleDone, tmoHit;
  logic accClear, accValid, accDone;
  logic [DATA_WIDTH-1:0] accAvg;

  logic metricFlush_q, metricFlush_d;
  logic perturbEn_q, perturbEn_d;
  logic perturbSign_q, perturbSign_d;
  logic resultValid_q, resultValid_d;
  logic busy_q, busy_d;
  logic timeoutErr_q, timeoutErr_d;
  logic [DATA_WIDTH-1:0] jPlus_q, jPlus_d, jMinus_q, jMinus_d;
  logic [DATA_WIDTH:0]   deltaJ_q, deltaJ_d;

  assign inMeas     = isMeas(state_q);
  assign settleDone = (cnt_q == '0);
  assign tmoHit     = inMeas && !accDone && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
  assign accClear   = !inMeas;
  assign accValid   = inMeas && metric_valid_i;

  spsa_meas_accum #(
    .DATA_WIDTH    (DATA_WIDTH),
    .METRIC_SAMPLES(METRIC_SAMPLES),
    .AVG_SHIFT     (AVG_SHIFT)
  ) u_accum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(accClear),
    .valid_i(accValid),
    .data_i (metric_in_i),
    .done_o (accDone),
    .avg_o  (accAvg)
  );

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      metricFlush_q <= 1'b0;
      perturbEn_q   <= 1'b0;
      perturbSign_q <= 1'b0;
      resultValid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeoutErr_q  <= 1'b0;
      jPlus_q       <= '0;
      jMinus_q      <= '0;
      deltaJ_q      <= '0;
    end else begin
      state_q       <= state_d;
      metricFlush_q <= metricFlush_d;
      perturbEn_q   <= perturbEn_d;
      perturbSign_q <= perturbSign_d;
      resultValid_q <= resultValid_d;
      busy_q        <= busy_d;
      timeoutErr_q  <= timeoutErr_d;
      jPlus_q       <= jPlus_d;
      jMinus_q      <= jMinus_d;
      deltaJ_q      <= deltaJ_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:     if (start_i) state_d = APPLY_P;
        APPLY_P:  state_d = SETTLE_P;
        SETTLE_P: if (settleDone) state_d = MEAS_P;
        MEAS_P:   if (accDone) state_d = APPLY_M; else if (tmoHit) state_d = IDLE;
        APPLY_M:  state_d = SETTLE_M;
        SETTLE_M: if (settleDone) state_d = MEAS_M;
        MEAS_M:   if (accDone) state_d = DONE; else if (tmoHit) state_d = IDLE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    metricFlush_d = (state_d == APPLY_P) || (state_d == APPLY_M);
    perturbEn_d   = (state_d != IDLE) && (state_d != DONE);
    perturbSign_d = isPlusPhase(state_d) ? POS : NEG;
    resultValid_d = (state_d == DONE);
    busy_d        = (state_d != IDLE);
    jPlus_d       = jPlus_q;
    jMinus_d      = jMinus_q;
    deltaJ_d      = deltaJ_q;
    timeoutErr_d  = timeoutErr_q;
    if ((state_q == MEAS_P) && (state_d == APPLY_M)) begin
      jPlus_d = accAvg;
    end
    if ((state_q == MEAS_M) && (state_d == DONE)) begin
      jMinus_d = accAvg;
      deltaJ_d = (DATA_WIDTH + 1)'(signed'(jPlus_q)) - (DATA_WIDTH + 1)'(signed'(accAvg));
    end
    if ((state_q == IDLE) && (state_d == APPLY_P)) begin
      timeoutErr_d = 1'b0;
    end else if (tmoHit && !abort_i) begin
      timeoutErr_d = 1'b1;
    end
  end

  // One counter serves both phases: counts down through SETTLE, up through MEAS for the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= isSettle(state_d) ? CNT_WIDTH'(SETTLE_CYCLES - 1) : '0;
    end else if (isSettle(state_q)) begin
      cnt_q <= cnt_q - 1'b1;
    end else if (inMeas) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign metric_flush_o = metricFlush_q;
  assign perturb_en_o   = perturbEn_q;
  assign perturb_sign_o = perturbSign_q;
  assign result_valid_o = resultValid_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = timeoutErr_q;
  assign j_plus_o       = jPlus_q;
  assign j_minus_o      = jMinus_q;
  assign delta_j_o      = deltaJ_q;

endmodule

// File: tb/tb_spsa_measure_sched.sv
// Self-checking bench for spsa_measure_sched; expected J+/J-/dJ come from plain arithmetic
// over the samples the bench itself chose. Honours SPSA_DISCARD_FIRST_EN.
module tb_spsa_measure_sched;

  localparam int DW      = 16;
  localparam int SETTLE  = 4;
  localparam int SAMPLES = 4;
  localparam int SHIFT   = 2;
  localparam int TMO     = 16;
  localparam int CW      = 16;
`ifdef SPSA_DISCARD_FIRST_EN
  localparam int DISC = 1;
`else
  localparam int DISC = 0;
`endif

  typedef logic [DW-1:0] sampleQ_t[$];

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          startReq = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] metricIn = '0;
  logic          metricValid = 1'b0;
  logic          metricFlush, perturbEn, perturbSign, resultValid, busy, timeoutErr;
  logic [DW-1:0] jPlus, jMinus;
  logic [DW:0]   deltaJ;

  int vectors = 0;
  int failures = 0;
  int flushSeen = 0;
  int resultSeen = 0;
  logic [DW-1:0] lastJp = '0;
  logic [DW-1:0] lastJm = '0;

  spsa_measure_sched #(
    .DATA_WIDTH    (DW),
    .SETTLE_CYCLES (SETTLE),
    .METRIC_SAMPLES(SAMPLES),
    .AVG_SHIFT     (SHIFT),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH     (CW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (startReq),
    .abort_i       (abort),
    .metric_in_i   (metricIn),
    .metric_valid_i(metricValid),
    .metric_flush_o(metricFlush),
    .perturb_en_o  (perturbEn),
    .perturb_sign_o(perturbSign),
    .j_plus_o      (jPlus),
    .j_minus_o     (jMinus),
    .delta_j_o     (deltaJ),
    .result_valid_o(resultValid),
    .busy_o        (busy),
    .timeout_err_o (timeoutErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    #1;
    flushSeen += int'(metricFlush);
    resultSeen += int'(resultValid);
  endtask

  function automatic logic [DW-1:0] avgOf(input sampleQ_t vals);
    int sum;
    sum = 0;
    for (int i = DISC; i < vals.size(); i++) sum += int'($signed(vals[i]));
    return DW'(sum >>> SHIFT);
  endfunction

  function automatic sampleQ_t mkQ(input logic [DW-1:0] a, b, c, d);
    sampleQ_t q;
    q = {};
    if (DISC != 0) q.push_back(16'h7FFF);
    q.push_back(a);
    q.push_back(b);
    q.push_back(c);
    q.push_back(d);
    return q;
  endfunction

  function automatic sampleQ_t randQ();
    sampleQ_t q;
    q = {};
    for (int i = 0; i < SAMPLES + DISC; i++) q.push_back(DW'($urandom));
    return q;
  endfunction

  task automatic idleDrive(input bit noisy);
    metricValid = noisy;
    metricIn = DW'($urandom);
  endtask

  task automatic settlePhase(input bit noisy, input logic sign, input string ph);
    for (int k = 0; k <= SETTLE; k++) begin
      idleDrive(noisy);
      stepClk();
      checkOutput({ph, " settle busy"}, 32'(busy), 32'(1));
      checkOutput({ph, " settle flush"}, 32'(metricFlush), 32'(0));
      checkOutput({ph, " settle perturb_en"}, 32'(perturbEn), 32'(1));
      checkOutput({ph, " settle sign"}, 32'(perturbSign), 32'(sign));
    end
    metricValid = 1'b0;
  endtask

  task automatic feedPhase(input sampleQ_t q, input bit gaps, input logic sign, input int abortIdx,
                           output bit aborted);
    int g;
    aborted = 1'b0;
    for (int i = 0; i < q.size(); i++) begin
      g = gaps ? int'($urandom_range(0, 1)) : 0;
      repeat (g) begin
        metricValid = 1'b0;
        stepClk();
        checkOutput("meas gap busy", 32'(busy), 32'(1));
        checkOutput("meas gap sign", 32'(perturbSign), 32'(sign));
      end
      metricValid = 1'b1;
      metricIn = q[i];
      abort = (i == abortIdx);
      stepClk();
      metricValid = 1'b0;
      abort = 1'b0;
      if (i == abortIdx) begin
        aborted = 1'b1;
        break;
      end
      if (i < q.size() - 1) checkOutput("meas result_valid", 32'(resultValid), 32'(0));
    end
  endtask

  task automatic applyStimulus(input sampleQ_t pv, input sampleQ_t mv, input bit noisy, input bit gaps,
                               input bit holdStart, input int abortIdx);
    logic [DW-1:0] expJp, expJm;
    logic [DW:0] expDelta;
    bit aborted;
    expJp = avgOf(pv);
    expJm = avgOf(mv);
    expDelta = (DW + 1)'(int'($signed(expJp)) - int'($signed(expJm)));
    flushSeen = 0;
    resultSeen = 0;
    startReq = 1'b1;
    stepClk();
    if (!holdStart) startReq = 1'b0;
    checkOutput("applyP busy", 32'(busy), 32'(1));
    checkOutput("applyP flush", 32'(metricFlush), 32'(1));
    checkOutput("applyP perturb_en", 32'(perturbEn), 32'(1));
    checkOutput("applyP sign", 32'(perturbSign), 32'(1));
    checkOutput("applyP timeout_err", 32'(timeoutErr), 32'(0));
    settlePhase(noisy, 1'b1, "plus");
    feedPhase(pv, gaps, 1'b1, -1, aborted);
    checkOutput("applyM flush", 32'(metricFlush), 32'(1));
    checkOutput("applyM sign", 32'(perturbSign), 32'(0));
    checkOutput("applyM perturb_en", 32'(perturbEn), 32'(1));
    checkOutput("applyM j_plus", 32'(jPlus), 32'(expJp));
    lastJp = expJp;
    settlePhase(noisy, 1'b0, "minus");
    feedPhase(mv, gaps, 1'b0, abortIdx, aborted);
    if (aborted) begin
      checkOutput("abort busy", 32'(busy), 32'(0));
      checkOutput("abort perturb_en", 32'(perturbEn), 32'(0));
      checkOutput("abort result_valid", 32'(resultValid), 32'(0));
      checkOutput("abort j_minus held", 32'(jMinus), 32'(lastJm));
      stepClk();
      checkOutput("abort no result pulse", 32'(resultSeen), 32'(0));
    end else begin
      checkOutput("done result_valid", 32'(resultValid), 32'(1));
      checkOutput("done perturb_en", 32'(perturbEn), 32'(0));
      checkOutput("done j_plus", 32'(jPlus), 32'(expJp));
      checkOutput("done j_minus", 32'(jMinus), 32'(expJm));
      checkOutput("done delta_j", 32'(deltaJ), 32'(expDelta));
      lastJm = expJm;
      stepClk();
      checkOutput("idle busy", 32'(busy), 32'(0));
      checkOutput("idle result_valid", 32'(resultValid), 32'(0));
      checkOutput("one result pulse", 32'(resultSeen), 32'(1));
    end
    checkOutput("two flush pulses", 32'(flushSeen), 32'(2));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'(0));
    checkOutput("reset perturb_en", 32'(perturbEn), 32'(0));
    checkOutput("reset sign", 32'(perturbSign), 32'(0));
    checkOutput("reset flush", 32'(metricFlush), 32'(0));
    checkOutput("reset result_valid", 32'(resultValid), 32'(0));
    checkOutput("reset timeout_err", 32'(timeoutErr), 32'(0));
    checkOutput("reset j_plus", 32'(jPlus), 32'(0));
    checkOutput("reset j_minus", 32'(jMinus), 32'(0));
    checkOutput("reset delta_j", 32'(deltaJ), 32'(0));
    rst_n = 1'b1;
    stepClk();

    applyStimulus(mkQ(16'h0100, 16'h0100, 16'h0100, 16'h0100),
                  mkQ(16'h0080, 16'h0080, 16'h0080, 16'h0080), 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(mkQ(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                  mkQ(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 1'b0, 1'b0, 1'b0, -1);
    applyStimulus(randQ(), randQ(), 1'b1, 1'b1, 1'b0, -1);
    for (int r = 0; r < 5; r++) begin
      applyStimulus(randQ(), randQ(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end

    applyStimulus(randQ(), randQ(), 1'b0, 1'b1, 1'b0, 2);
    applyStimulus(randQ(), randQ(), 1'b1, 1'b0, 1'b0, -1);

    resultSeen = 0;
    startReq = 1'b1;
    stepClk();
    startReq = 1'b0;
    settlePhase(1'b0, 1'b1, "timeout");
    for (int c = 1; c < TMO; c++) stepClk();
    checkOutput("timeout last meas busy", 32'(busy), 32'(1));
    checkOutput("timeout not yet set", 32'(timeoutErr), 32'(0));
    stepClk();
    checkOutput("timeout busy", 32'(busy), 32'(0));
    checkOutput("timeout err set", 32'(timeoutErr), 32'(1));
    checkOutput("timeout perturb_en", 32'(perturbEn), 32'(0));
    checkOutput("timeout j_plus held", 32'(jPlus), 32'(lastJp));
    repeat (3) stepClk();
    checkOutput("timeout err sticky", 32'(timeoutErr), 32'(1));
    checkOutput("timeout no result", 32'(resultSeen), 32'(0));
    applyStimulus(randQ(), randQ(), 1'b0, 1'b0, 1'b0, -1);

    applyStimulus(randQ(), randQ(), 1'b1, 1'b1, 1'b1, -1);
    abort = 1'b1;
    stepClk();
    checkOutput("abort+start stays idle", 32'(busy), 32'(0));
    checkOutput("abort+start no flush", 32'(metricFlush), 32'(0));
    startReq = 1'b0;
    abort = 1'b0;
    stepClk();
    checkOutput("after abort+start idle", 32'(busy), 32'(0));
    checkOutput("after abort+start no result", 32'(resultValid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, failures);
    $finish;
  end

endmodule
